// File: rtl/capp_pkg.sv
// Shared types and width helpers for the tag sequencer.
//   state_e     : FSM state encoding (IDLE, SCAN, DONE)
//   idx_width() : width of a binary index into n cells (at least 1 bit)
//   cnt_width() : width of a counter that must reach n without wrapping
package capp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tag_sequencer_if.sv
// Response channel of the tag sequencer (valid/ready handshake).
//   master : drives resp_valid, resp_index, resp_onehot, resp_last; samples resp_ready
//   slave  : consumer side, drives resp_ready
interface tag_sequencer_if #(
  parameter int num_cells = 100,
  parameter int IDX_W     = capp_pkg::idx_width(num_cells)
) ();

  logic                 resp_valid;
  logic                 resp_ready;
  logic [IDX_W-1:0]     resp_index;
  logic [num_cells-1:0] resp_onehot;
  logic                 resp_last;

  modport master (
    output resp_valid, resp_index, resp_onehot, resp_last,
    input  resp_ready
  );

  modport slave (
    input  resp_valid, resp_index, resp_onehot, resp_last,
    output resp_ready
  );

endinterface

// File: rtl/lowest_set_isolate.sv
// Combinational lowest-set-bit isolation.
//   vec_in     : input vector
//   onehot_out : lowest set bit of vec_in as one-hot (0 when vec_in is 0)
//   index_out  : binary index of onehot_out
//   single_out : vec_in has exactly one bit set
module lowest_set_isolate #(
  parameter int WIDTH = 100,
  parameter int IDX_W = capp_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_in,
  output logic [WIDTH-1:0] onehot_out,
  output logic [IDX_W-1:0] index_out,
  output logic             single_out
);

  logic [WIDTH-1:0] iso;

  always_comb begin
    // Two's-complement trick: x & -x keeps only the lowest set bit.
    iso        = vec_in & (~vec_in + WIDTH'(1));
    onehot_out = iso;
    index_out  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (iso[i]) index_out = index_out | IDX_W'(i);
    end
    single_out = (vec_in != '0) && ((vec_in & (vec_in - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/tag_sequencer.sv
// Tag sequencer: captures a tag vector on start and reports each set bit,
// lowest index first, one per accepted handshake on the response channel.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   start/abort : begin a pass / terminate an active pass
//   tags_in     : tag vector sampled on an accepted start
//   resp_if     : response channel (master side)
//   busy        : high in SCAN and DONE
//   done        : one-cycle pulse at normal pass completion
//   match_count : responses accepted in the current or most recent pass
module tag_sequencer
  import capp_pkg::*;
#(
  parameter int num_cells = 100,
  parameter int IDX_W     = idx_width(num_cells),
  parameter int CNT_W     = cnt_width(num_cells)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 start,
  input  logic                 abort,
  input  logic [num_cells-1:0] tags_in,
  tag_sequencer_if.master      resp_if,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     match_count
);

  state_e               state_q, state_d;
  logic [num_cells-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [num_cells-1:0] low_onehot;
  logic [IDX_W-1:0]     low_index;
  logic                 low_single;
  logic                 in_scan;
  logic                 resp_valid;

  lowest_set_isolate #(
    .WIDTH (num_cells),
    .IDX_W (IDX_W)
  ) u_isolate (
    .vec_in     (pending_q),
    .onehot_out (low_onehot),
    .index_out  (low_index),
    .single_out (low_single)
  );

  // Response outputs come straight from registered state, so reset clears them at once.
  assign in_scan             = (state_q == SCAN);
  assign resp_valid          = in_scan && (pending_q != '0);
  assign resp_if.resp_valid  = resp_valid;
  assign resp_if.resp_onehot = in_scan ? low_onehot : '0;
  assign resp_if.resp_index  = in_scan ? low_index : '0;
  assign resp_if.resp_last   = in_scan && low_single;
  assign busy                = (state_q != IDLE);
  assign done                = (state_q == DONE);
  assign match_count         = count_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          pending_d = tags_in;
          count_d   = '0;
          state_d   = (tags_in != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        // Abort takes priority: a simultaneous handshake is neither consumed nor counted.
        if (abort) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (resp_valid && resp_if.resp_ready) begin
          pending_d = pending_q & ~low_onehot;
          count_d   = count_q + CNT_W'(1);
          if (low_single) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_tag_sequencer.sv
// Bench for tag_sequencer with num_cells = 8: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_tag_sequencer;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  tags_in = '0;
  logic          busy, done;
  logic [CW-1:0] match_count;

  tag_sequencer_if #(.num_cells(N)) resp_if ();

  tag_sequencer #(.num_cells(N)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .abort       (abort),
    .tags_in     (tags_in),
    .resp_if     (resp_if),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [18:0] got;

  // Reference model: the pass is a queue of cell indices still to be reported.
  int m_q[$];
  bit m_scan, m_done;
  int m_cnt;

  function automatic logic [18:0] pack(input bit b, input bit d, input bit v, input bit l,
                                       input int idx, input int cnt);
    logic [7:0] oh;
    oh = v ? (8'd1 << idx) : 8'd0;
    return {b, d, v, l, idx[2:0], oh, cnt[3:0]};
  endfunction

  function automatic logic [18:0] observe();
    return {busy, done, resp_if.resp_valid, resp_if.resp_last, resp_if.resp_index,
            resp_if.resp_onehot, match_count};
  endfunction

  function automatic logic [18:0] model_exp();
    bit v;
    v = m_scan && (m_q.size() > 0);
    return pack(m_scan || m_done, m_done, v, v && (m_q.size() == 1), v ? m_q[0] : 0, m_cnt);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_scan = 0;
    m_done = 0;
    m_cnt  = 0;
  endfunction

  function automatic void model_edge(input bit s, input bit a, input bit r, input logic [7:0] t);
    if (m_done) begin
      m_done = 0;
    end else if (m_scan) begin
      if (a) begin
        m_q.delete();
        m_scan = 0;
      end else if (r) begin
        void'(m_q.pop_front());
        m_cnt++;
        if (m_q.size() == 0) begin
          m_scan = 0;
          m_done = 1;
        end
      end
    end else if (s && !a) begin
      m_q.delete();
      for (int i = 0; i < 8; i++) if (t[i]) m_q.push_back(i);
      m_cnt = 0;
      if (m_q.size() > 0) m_scan = 1;
      else m_done = 1;
    end
  endfunction

  // Drive one cycle of inputs on the falling edge; return 1 ns after the rising edge.
  task automatic step(input bit s, input bit a, input bit r, input logic [7:0] t);
    @(negedge CLK);
    start = s;
    abort = a;
    resp_if.resp_ready = r;
    tags_in = t;
    @(posedge CLK);
    model_edge(s, a, r, t);
    #1;
  endtask

  task automatic test_reset();
    resp_if.resp_ready = 1'b0;
    model_reset();
    #2;
    got = observe();
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", got, 19'h0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_basic();
    logic [18:0] exp [5];
    exp = '{pack(1,0,1,0,2,0), pack(1,0,1,0,5,1), pack(1,0,1,1,7,2),
            pack(1,1,0,0,0,3), pack(0,0,0,0,0,3)};
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 0, 1, 8'hA4);
      got = observe();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL basic_a4 step%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_zero_tags();
    logic [18:0] exp [2];
    exp = '{pack(1,1,0,0,0,0), pack(0,0,0,0,0,0)};
    for (int i = 0; i < 2; i++) begin
      step(i == 0, 0, 1, 8'h00);
      got = observe();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL zero_tags step%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] exp [7];
    bit rdy [7];
    rdy = '{0, 0, 0, 0, 1, 1, 1};
    exp = '{pack(1,0,1,0,0,0), pack(1,0,1,0,0,0), pack(1,0,1,0,0,0), pack(1,0,1,0,0,0),
            pack(1,0,1,1,7,1), pack(1,1,0,0,0,2), pack(0,0,0,0,0,2)};
    for (int i = 0; i < 7; i++) begin
      step(i == 0, 0, rdy[i], 8'h81);
      got = observe();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL backpressure step%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_abort_scan();
    logic [18:0] exp [5];
    exp = '{pack(1,0,1,0,0,0), pack(1,0,1,0,1,1), pack(1,0,1,0,2,2),
            pack(0,0,0,0,0,2), pack(0,0,0,0,0,2)};
    for (int i = 0; i < 5; i++) begin
      step(i == 0, i == 3, 1, 8'hFF);
      got = observe();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL abort_scan step%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [18:0] exp [4];
    logic [7:0] tg [4];
    tg  = '{8'h24, 8'hFF, 8'h01, 8'h01};
    exp = '{pack(1,0,1,0,2,0), pack(1,0,1,1,5,1), pack(1,1,0,0,0,2), pack(0,0,0,0,0,2)};
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 0, 1, tg[i]);
      got = observe();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL start_ignored step%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_abort_idle();
    for (int i = 0; i < 2; i++) begin
      step(1, i == 0, 1, 8'h0F);
      if (i == 0) begin
        got = observe();
        checks++;
        if (got !== pack(0,0,0,0,0,2)) begin
          errors++;
          $display("FAIL abort_idle got %h want %h", got, pack(0,0,0,0,0,2));
        end
      end
    end
    // The second step was a plain start: it must have begun a pass at cell 0.
    got = observe();
    checks++;
    if (got !== pack(1,0,1,0,0,0)) begin
      errors++;
      $display("FAIL start_after_abort got %h want %h", got, pack(1,0,1,0,0,0));
    end
    step(0, 1, 0, 8'h00);
  endtask

  task automatic test_reset_mid_scan();
    logic [18:0] exp [3];
    step(1, 0, 0, 8'hFF);
    step(0, 0, 1, 8'hFF);
    got = observe();
    checks++;
    if (got !== pack(1,0,1,0,1,1)) begin
      errors++;
      $display("FAIL pre_reset got %h want %h", got, pack(1,0,1,0,1,1));
    end
    @(negedge CLK);
    RST_N = 1'b0;
    model_reset();
    #1;
    got = observe();
    checks++;
    if (got !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid_scan got %h want %h", got, 19'h0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    resp_if.resp_ready = 1'b0;
    tags_in = 8'h10;
    @(posedge CLK);
    model_edge(1, 0, 0, 8'h10);
    #1;
    exp = '{pack(1,0,1,1,4,0), pack(1,1,0,0,0,1), pack(0,0,0,0,0,1)};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(0, 0, 1, 8'h10);
      got = observe();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL post_reset step%0d got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_random();
    bit s, a, r;
    logic [7:0] t;
    for (int i = 0; i < 800; i++) begin
      s = ($urandom % 3) == 0;
      a = ($urandom % 25) == 0;
      r = ($urandom % 10) < 7;
      case ($urandom % 4)
        0:       t = 8'h00;
        1:       t = 8'd1 << ($urandom % 8);
        default: t = 8'($urandom);
      endcase
      step(s, a, r, t);
      got = observe();
      checks++;
      if (got !== model_exp()) begin
        errors++;
        $display("FAIL random cycle%0d got %h want %h", i, got, model_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_tags();
    test_backpressure();
    test_abort_scan();
    test_start_ignored();
    test_abort_idle();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
